// File: rtl/pump3_sequencer_if.sv
// rtl/pump3_sequencer_if.sv - host/valve bus for pump3_sequencer (abort exists with PUMP3_SEQ_ABORT_EN)
interface pump3_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] strokes;
  logic             air1;
  logic             air2;
  logic             air3;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] stroke_cnt;
`ifdef PUMP3_SEQ_ABORT_EN
  logic             abort;

  modport master (
    output start, dir, strokes, abort,
    input  air1, air2, air3, busy, done, stroke_cnt
  );

  modport slave (
    input  start, dir, strokes, abort,
    output air1, air2, air3, busy, done, stroke_cnt
  );
`else
  modport master (
    output start, dir, strokes,
    input  air1, air2, air3, busy, done, stroke_cnt
  );

  modport slave (
    input  start, dir, strokes,
    output air1, air2, air3, busy, done, stroke_cnt
  );
`endif
endinterface

// File: rtl/pump3_sequencer.sv
// rtl/pump3_sequencer.sv - six-phase peristaltic valve sequencer; optional abort via PUMP3_SEQ_ABORT_EN
module pump3_sequencer #(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pump3_sequencer_if.slave       bus
);

  localparam int DW = $clog2(PHASE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(PHASE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] strokes_q, strokes_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       air_q, air_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_req;
  logic             last_phase;

  // Valve pattern {air1,air2,air3} in forward order; reverse walks it backwards.
  function automatic logic [2:0] pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    pattern = 3'b011;
      3'd1:    pattern = 3'b001;
      3'd2:    pattern = 3'b101;
      3'd3:    pattern = 3'b100;
      3'd4:    pattern = 3'b110;
      3'd5:    pattern = 3'b010;
      default: pattern = 3'b111;
    endcase
  endfunction

`ifdef PUMP3_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_phase = dir_q ? (phase_q == 3'd0) : (phase_q == 3'd5);

  // Next-state logic: command acceptance, dwell/phase/stroke advance, abort.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    dir_d     = dir_q;
    strokes_d = strokes_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          if (bus.strokes != '0) begin
            dir_d     = bus.dir;
            strokes_d = bus.strokes;
            phase_d   = bus.dir ? 3'd5 : 3'd0;
            dwell_d   = '0;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          // Abort wins over any advance this cycle; stroke count is kept.
          state_d = ST_IDLE;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (last_phase) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == strokes_q) begin
              state_d = ST_DONE;
            end else begin
              phase_d = dir_q ? 3'd5 : 3'd0;
            end
          end else begin
            phase_d = dir_q ? phase_q - 3'd1 : phase_q + 3'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they are registered yet aligned with it.
  always_comb begin
    air_d  = 3'b111;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == ST_RUN) begin
      air_d  = pattern(phase_d);
      busy_d = 1'b1;
    end
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  // State and output registers; reset parks all valves closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      dwell_q   <= '0;
      dir_q     <= 1'b0;
      strokes_q <= '0;
      cnt_q     <= '0;
      air_q     <= 3'b111;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      dir_q     <= dir_d;
      strokes_q <= strokes_d;
      cnt_q     <= cnt_d;
      air_q     <= air_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.air1       = air_q[2];
  assign bus.air2       = air_q[1];
  assign bus.air3       = air_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stroke_cnt = cnt_q;

endmodule

// File: tb/tb_pump3_sequencer.sv
// tb/tb_pump3_sequencer.sv - directed and randomized checks of pump3_sequencer against a phase-table model
module tb_pump3_sequencer;

  localparam int P     = 2;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [2:0] fwd_pat [6];

  pump3_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pump3_sequencer #(.PHASE_CYCLES(P), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [CNT_W-1:0] exp_cnt, input logic exp_done);
    chk({tag, "_air"},  {29'd0, bus.air1, bus.air2, bus.air3}, 32'h7);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, exp_done});
    chk({tag, "_cnt"},  {24'd0, bus.stroke_cnt}, {24'd0, exp_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command and check every cycle against the expected air trace.
  // poke >= 0 re-pulses start with other settings at that RUN cycle.
  task automatic run_cmd(input string tag, input logic d, input int n, input int poke);
    logic [2:0] exp_air [$];
    int         len;
    exp_air = {};
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < 6; k++) begin
        for (int c = 0; c < P; c++) begin
          exp_air.push_back(d ? fwd_pat[5 - k] : fwd_pat[k]);
        end
      end
    end
    len = exp_air.size();
    bus.start   = 1'b1;
    bus.dir     = d;
    bus.strokes = CNT_W'(n);
    tick();
    bus.start   = 1'b0;
    bus.dir     = ~d;
    bus.strokes = CNT_W'($urandom_range(1, 200));
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_air%0d", tag, i), {29'd0, bus.air1, bus.air2, bus.air3}, {29'd0, exp_air[i]});
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("%s_done%0d", tag, i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("%s_cnt%0d", tag, i), {24'd0, bus.stroke_cnt}, 32'(i / (6 * P)));
      bus.start = (i == poke);
      if (i == poke) begin
        bus.dir     = ~d;
        bus.strokes = CNT_W'($urandom_range(1, 9));
      end
      tick();
    end
    bus.start = 1'b0;
    chk_idle({tag, "_donecyc"}, CNT_W'(n), 1'b1);
    tick();
    chk_idle({tag, "_back"}, CNT_W'(n), 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    fwd_pat[0] = 3'b011;
    fwd_pat[1] = 3'b001;
    fwd_pat[2] = 3'b101;
    fwd_pat[3] = 3'b100;
    fwd_pat[4] = 3'b110;
    fwd_pat[5] = 3'b010;
    bus.start   = 1'b0;
    bus.dir     = 1'b0;
    bus.strokes = '0;
`ifdef PUMP3_SEQ_ABORT_EN
    bus.abort   = 1'b0;
`endif
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #3;
    chk_idle("reset", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset", '0, 1'b0);

    run_cmd("fwd1", 1'b0, 1, -1);
    run_cmd("rev2", 1'b1, 2, -1);

    // Zero-stroke command completes immediately without actuation.
    bus.start   = 1'b1;
    bus.strokes = '0;
    tick();
    bus.start = 1'b0;
    chk_idle("zero", '0, 1'b1);
    tick();
    chk_idle("zero_back", '0, 1'b0);

    run_cmd("ignore_start", 1'b0, 2, 7);

    for (int r = 0; r < 6; r++) begin
      int rn;
      int rp;
      rn = $urandom_range(1, 4);
      rp = $urandom_range(0, rn * 6 * P - 2);
      run_cmd($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), rn, ($urandom_range(0, 1) == 1) ? rp : -1);
    end

    // Asynchronous reset in the middle of a command: no done pulse follows.
    bus.start   = 1'b1;
    bus.dir     = 1'b0;
    bus.strokes = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("midrst", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("midrst_after%0d", i), '0, 1'b0);
    end

`ifdef PUMP3_SEQ_ABORT_EN
    bus.start   = 1'b1;
    bus.dir     = 1'b1;
    bus.strokes = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6 * P + 3; i++) tick();
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("abort", 8'd1, 1'b0);
    tick();
    chk_idle("abort_after", 8'd1, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("abort_idle", 8'd1, 1'b0);
    run_cmd("after_abort", 1'b0, 1, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pump3_sequencer.md
# pump3_sequencer

Clocked actuation controller that drives the three air-control lines of a three-valve peristaltic pump (pump1/pump2/pump3 inputs of the pump3 stage) from a host command. It accepts a stroke count and direction, then steps the valves through a fixed six-phase peristaltic pattern with a programmable dwell per phase. It signals completion, and parks all valves closed when idle. It sits between the host/pin-driver logic and the off-chip solenoid drivers that pressurise the pump's air inputs.

## Interface
- PHASE_CYCLES, 4, clock cycles each phase is held (>= 1)
- CNT_W, 8, width of stroke count and stroke counter
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command strobe; sampled only in IDLE
- dir  input  1  0 = forward (in→out), 1 = reverse; latched on accepted start
- strokes  input  CNT_W  number of full 6-phase strokes; latched on accepted start
- air1, air2, air3  output  1 each  air line drive; 1 = pressurised (valve closed), 0 = vented (open)
- busy  output  1  high while pumping (RUN)
- done  output  1  one-cycle completion pulse
- stroke_cnt  output  CNT_W  strokes completed in the current/last command
- abort  input  1  present only with PUMP3_SEQ_ABORT_EN

## Operation
- Reset is asynchronous and active-low. One clock domain; all outputs registered.
- States: IDLE, RUN, DONE.
- IDLE: air = 111, busy = 0, done = 0. If start = 1 and strokes != 0, latch dir/strokes, clear stroke_cnt, load phase index 0 and dwell counter, go to RUN. If start = 1 and strokes == 0, go directly to DONE without actuation, with stroke_cnt cleared.
- RUN: air = pattern[phase]; busy = 1.
  - Dwell counter counts PHASE_CYCLES cycles per phase.
  - Forward phase order {air1,air2,air3}: 011, 001, 101, 100, 110, 010.
  - Reverse walks the same table from index 5 down to 0.
  - On leaving the last phase of a stroke, stroke_cnt increments. If the new value equals the latched strokes, go to DONE; otherwise wrap the phase index to the start and continue.
- DONE: air = 111, busy = 0, done = 1 for exactly one cycle, then IDLE. stroke_cnt holds until the next accepted start.
- start outside IDLE (RUN or DONE) is ignored. Changes to dir/strokes after acceptance have no effect.
- Dwell counter width: $clog2(PHASE_CYCLES+1). Stroke counter width: CNT_W, no wrap beyond the latched strokes value (maximum 2^CNT_W−1).

## Timing
- Reset values: air1 = air2 = air3 = 1, busy = 0, done = 0, stroke_cnt = 0, state = IDLE.
- start sampled high at edge k (IDLE): from edge k, air = first phase and busy = 1.
- Each phase is visible for exactly PHASE_CYCLES cycles. Phase transitions have no gaps or overlap.
- A command of N strokes holds busy for 6·PHASE_CYCLES·N cycles. done is high in the following cycle, with air = 111 in that same cycle.
- strokes = 0: done is high in the cycle after the accepted start; busy never rises.
- Earliest next accepted start is the cycle after done (state back in IDLE).
- rst_n low mid-RUN: outputs go to reset values immediately (asynchronously), and no done pulse is produced.

## Configuration
- PUMP3_SEQ_ABORT_EN defined:
  - abort input exists. abort = 1 at an edge in RUN forces IDLE at that edge, with air = 111 and busy = 0. No done pulse is produced.
  - stroke_cnt holds the strokes completed so far.
  - abort in IDLE/DONE is ignored. abort has priority over the phase/stroke advance in the same cycle.
- PUMP3_SEQ_ABORT_EN undefined: no abort port, and a command always runs to completion or reset.

## Test plan
- Reset: assert rst_n = 0 mid-clock → air = 111, busy = 0, done = 0, stroke_cnt = 0 without waiting for a clock edge.
- Forward, PHASE_CYCLES = 2, strokes = 1, dir = 0 → air sequence 011,011,001,001,101,101,100,100,110,110,010,010. Then one cycle of air = 111 with done = 1, and stroke_cnt = 1. busy is high for 12 cycles.
- Reverse, strokes = 2, dir = 1 → the sequence 010,110,100,101,001,011 is repeated twice. stroke_cnt steps 0→1→2, and done pulses once after 24 cycles (PHASE_CYCLES = 2).
- strokes = 0 with start → done = 1 the next cycle, busy stays 0, air stays 111.
- start pulsed mid-RUN with a different dir/strokes → no restart; the original command completes with its original length and direction.
- (PUMP3_SEQ_ABORT_EN) abort during stroke 2 of 3 → next cycle air = 111, busy = 0, done stays 0, stroke_cnt = 1. A subsequent start is accepted normally.
